muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multiply/divide sequencer that owns the HI/LO register pair used by mult, div, mfhi and mflo. It accepts an operation from the decode/execute stage, runs a one-bit-per-cycle shift-add multiply or restoring divide, and writes the 2·WIDTH-bit result into HI/LO. It also raises a pipeline stall when an mfhi/mflo read arrives while an operation is still in flight.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  operation select:
  - 00 MULT (signed).
  - 01 MULTU.
  - 10 DIV (signed).
  - 11 DIVU.
- a  in  WIDTH  rs operand (multiplicand or dividend), latched on accept.
- b  in  WIDTH  rt operand (multiplier or divisor), latched on accept.
- rd_req  in  1  mfhi/mflo in execute this cycle.
- busy  out  1  state != IDLE (combinational from state).
- stall  out  1  rd_req & busy (combinational).
- done  out  1  registered one-cycle pulse when HI/LO are updated.
- div_by_zero  out  1  registered; set with done on a divide with b == 0, cleared on next accept.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States:
  - IDLE: start=1 accepts. Latch |a| and |b|, record sign flags, set count=0, go to CALC.
  - CALC: perform one iteration per cycle. After the iteration with count==WIDTH-1, go to FIX.
  - FIX: apply sign correction, write hi/lo, pulse done, go to IDLE.
- Signed magnitude handling:
  - |x| is the WIDTH-bit two's-complement negation when the signed op's x[WIDTH-1]==1; otherwise x.
  - Unsigned ops never negate.
- Multiply: shift-add on a 2·WIDTH-bit accumulator.
  - FIX result: {hi,lo} = product, negated (2·WIDTH bits) when sa^sb on MULT.
- Divide: restoring division.
  - Remainder register WIDTH+1 bits; quotient shifts in one bit per cycle.
  - FIX result: lo = quotient, negated if sa^sb; hi = remainder, negated if sa (DIV only).
- Most-negative / -1 (DIV): lo = 2^(WIDTH-1) pattern (0x80000000), hi = 0. No trap.
- Divide by zero (b==0 at accept):
  - Still runs the full latency.
  - FIX forces hi = original a, lo = all ones, div_by_zero=1.
- start while busy: ignored. Latched operands are unaffected. No queueing.
- start in the same cycle as done: accepted, since state is IDLE.
- hi/lo hold their value between operations and change only in FIX.
- rst at any point:
  - state=IDLE, count=0.
  - hi=0, lo=0, done=0, div_by_zero=0.
  - Any in-flight operation is discarded with no done pulse.

## Timing
- Accept at edge E0 (start=1 in IDLE). busy=1 from E0 through E0+WIDTH+1.
- FIX occupies the cycle ending at edge E0+WIDTH+1. After that edge:
  - hi/lo are valid.
  - done=1 for exactly one cycle.
  - busy=0.
- Latency from accept to result is WIDTH+1 cycles (33 at WIDTH=32).
- stall is combinational. It is high in every cycle where rd_req=1 and busy=1, and low in the done cycle.
- An mfhi/mflo issued in the done cycle reads the new hi/lo.
- Reset values: busy=0, stall=0, done=0, div_by_zero=0, hi=0, lo=0.

## Configuration
- MULDIV_DIV_EN defined: all four ops are supported as above.
- MULDIV_DIV_EN undefined:
  - Divide datapath is not compiled.
  - start with op[1]=1 is ignored: no busy, no done, hi/lo unchanged.
  - div_by_zero is tied 0.
  - MULT/MULTU behaviour and timing are identical to the defined case.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done 33 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100 b=7 -> lo=14, hi=2. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV a=0x1234 b=0 -> hi=0x00001234, lo=0xFFFFFFFF, div_by_zero=1; the next MULTU accept clears div_by_zero.
- MULTU 5×6 with a second start (a=b=9) held high for 5 cycles after accept, plus rd_req=1 throughout -> stall=1 for 33 cycles, stall=0 in the done cycle; result hi=0, lo=30.
- MULTU accepted, rst pulsed 10 cycles later -> busy=0, hi=lo=0 next cycle; no done pulse within 40 cycles.
- Without MULDIV_DIV_EN: DIVU start -> busy stays 0, hi/lo unchanged.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative shift-add multiply / restoring divide owning the HI/LO pair.
// Define MULDIV_DIV_EN to build DIV/DIVU; without it divide requests are ignored.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_req,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2;
    logic [1:0] state;
    logic [CW-1:0] count;
    logic [WIDTH-1:0] ma, abs_a, abs_b;
    logic [2*WIDTH-1:0] acc, acc_step, prod, res;
    logic [WIDTH:0] sum;
    logic sa, sb, accept, last;
    assign busy = state != IDLE;
    assign stall = rd_req & busy;
    assign abs_a = (~op[0] & a[WIDTH-1]) ? -a : a;
    assign abs_b = (~op[0] & b[WIDTH-1]) ? -b : b;
    assign last = count == CW'(WIDTH - 1);
    // multiplier sits in acc low half and is consumed LSB-first as the product shifts in
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, ma} : {(WIDTH + 1){1'b0}});
    assign prod = (sa ^ sb) ? -acc : acc;
`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0] mb, rem, res_hi, res_lo;
    logic [WIDTH:0] shifted, diff;
    logic is_div, dz;
    assign accept = start & ~busy;
    assign shifted = {rem, acc[WIDTH-1]};
    assign diff = shifted - {1'b0, mb};
    assign acc_step = is_div ? {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~diff[WIDTH]} : {sum, acc[WIDTH-1:1]};
    // ma is |a|, so re-negating it on a signed op recovers the original dividend
    assign res_hi = dz ? (sa ? -ma : ma) : (sa ? -rem : rem);
    assign res_lo = dz ? {WIDTH{1'b1}} : ((sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    assign res = is_div ? {res_hi, res_lo} : prod;
    always_ff @(posedge clk) begin
        if (rst) begin
            div_by_zero <= 1'b0;
            is_div <= 1'b0;
            dz <= 1'b0;
            mb <= '0;
            rem <= '0;
        end else if (accept) begin
            is_div <= op[1];
            dz <= b == '0;
            mb <= abs_b;
            rem <= '0;
            div_by_zero <= 1'b0;
        end else if (state == CALC && is_div) begin
            rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        end else if (state == FIX && is_div) begin
            div_by_zero <= dz;
        end
    end
`else
    assign accept = start & ~busy & ~op[1];
    assign acc_step = {sum, acc[WIDTH-1:1]};
    assign res = prod;
    assign div_by_zero = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            hi <= '0;
            lo <= '0;
            done <= 1'b0;
            sa <= 1'b0;
            sb <= 1'b0;
            ma <= '0;
            acc <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state <= CALC;
                count <= '0;
                sa <= ~op[0] & a[WIDTH-1];
                sb <= ~op[0] & b[WIDTH-1];
                ma <= abs_a;
                acc <= {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
            end else if (state == CALC) begin
                state <= last ? FIX : CALC;
                count <= count + 1'b1;
                acc <= acc_step;
            end else if (state == FIX) begin
                state <= IDLE;
                {hi, lo} <= res;
                done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and random checks of muldiv_sequencer against an arithmetic model.
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic rst, start, rd_req, busy, stall, done, div_by_zero;
    logic [1:0] op;
    logic [31:0] a, b, hi, lo;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .rd_req(rd_req),
        .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eh, output logic [31:0] el, output logic ez);
        longint p;
        logic [63:0] u;
        ez = 1'b0;
        if (o == 2'd0) begin
            p = longint'($signed(x)) * longint'($signed(y));
            {eh, el} = p;
        end else if (o == 2'd1) begin
            u = {32'b0, x} * {32'b0, y};
            {eh, el} = u;
        end else if (y == 0) begin
            eh = x;
            el = 32'hFFFF_FFFF;
            ez = 1'b1;
        end else if (o == 2'd2) begin
            p = longint'($signed(x)) / longint'($signed(y));
            el = p[31:0];
            p = longint'($signed(x)) % longint'($signed(y));
            eh = p[31:0];
        end else begin
            el = x / y;
            eh = x % y;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [31:0] eh, el;
        logic ez;
        int lat, bcnt;
        model(o, x, y, eh, el, ez);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_dbz_clr"}, div_by_zero, 0);
        bcnt = busy;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            bcnt += busy;
        end
        chk({tag, "_latency"}, lat, 33);
        chk({tag, "_busy_cycles"}, bcnt, 33);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        chk({tag, "_dbz"}, div_by_zero, ez);
    endtask

    initial begin
        logic [31:0] ph, pl, x, y;
        logic [1:0] o;
        int lat, scnt, seen;
        rst = 1'b1; start = 1'b0; rd_req = 1'b0; op = 2'd0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        rd_req = 1'b1;
        #1;
        chk("rst_stall", stall, 0);
        rd_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        chk("multu_max_hi_const", hi, 32'hFFFF_FFFE);
        chk("multu_max_lo_const", lo, 32'h0000_0001);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg");
        chk("mult_neg_lo_const", lo, 32'hFFFF_FFEB);
`ifdef MULDIV_DIV_EN
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
        chk("div_neg_lo_const", lo, 32'hFFFF_FFFD);
        run_op(2'd3, 32'd100, 32'd7, "divu");
        chk("divu_lo_const", lo, 32'd14);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_minneg");
        chk("div_minneg_lo_const", lo, 32'h8000_0000);
        run_op(2'd2, 32'h0000_1234, 32'd0, "div_zero");
        chk("div_zero_flag", div_by_zero, 1);
        run_op(2'd1, 32'd3, 32'd5, "multu_after_dz");
`else
        ph = hi; pl = lo;
        @(negedge clk);
        start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        repeat (40) begin
            seen |= int'(busy | done);
            @(posedge clk); #1;
        end
        chk("nodiv_ignored", seen, 0);
        chk("nodiv_hi", hi, ph);
        chk("nodiv_lo", lo, pl);
        chk("nodiv_dbz", div_by_zero, 0);
`endif

        // stall window with a second start held during the operation
        @(negedge clk);
        start = 1'b1; op = 2'd1; a = 32'd5; b = 32'd6; rd_req = 1'b1;
        @(posedge clk); #1;
        a = 32'd9; b = 32'd9;
        scnt = stall;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 5) start = 1'b0;
            scnt += stall;
        end
        start = 1'b0;
        chk("stall_latency", lat, 33);
        chk("stall_cycles", scnt, 33);
        chk("stall_done_low", stall, 0);
        chk("stall_hi", hi, 0);
        chk("stall_lo", lo, 30);
        rd_req = 1'b0;

        for (int i = 0; i < 16; i++) begin
`ifdef MULDIV_DIV_EN
            o = 2'($urandom_range(0, 3));
`else
            o = 2'($urandom_range(0, 1));
`endif
            x = $urandom;
            y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (i % 4 == 1) y = y & 32'hFF;
            run_op(o, x, y, $sformatf("rand%0d_op%0d", i, o));
        end

        // reset mid-operation discards it
        @(negedge clk);
        start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_hi", hi, 0);
        chk("rstmid_lo", lo, 0);
        chk("rstmid_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= int'(done);
        end
        chk("rstmid_no_done", seen, 0);
        chk("rstmid_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
